d_wb_arbiter: RTL and testbench



---
 rtl/d_wb_arbiter.sv | 89 ++++++++
 tb/tb_d_wb_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/d_wb_arbiter.sv
// rtl/d_wb_arbiter.sv - writeback arbiter: fixed-priority ALU path plus FIFO-buffered long-latency path
module d_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_we,
  input  logic [4:0]    alu_rd,
  input  logic [31:0]   alu_data,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic [4:0]    lsu_rd,
  input  logic [31:0]   lsu_data,
  output logic          we,
  output logic [4:0]    rw,
  output logic [31:0]   busw,
  output logic [CW-1:0] fifo_count,
  output logic [31:0]   busy_mask,
  output logic          order_err
);
  localparam int            AW   = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]      data_q [DEPTH];
  logic [4:0]       rd_q   [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_n;
  logic [AW-1:0]    head, tail;
  logic             alu_sel, push, pop;
  logic [31:0]      busy_n;

  assign lsu_ready = (fifo_count != FULL);
  assign alu_sel   = alu_we && (alu_rd != 5'd0);
  // rd=0 pushes finish the handshake but never occupy a slot
  assign push      = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
  assign pop       = !alu_sel && (fifo_count != '0);

  // Occupancy after this edge; the tail slot takes its rd from the incoming push
  always_comb begin
    valid_n = valid_q;
    if (pop)  valid_n[head] = 1'b0;
    if (push) valid_n[tail] = 1'b1;
    busy_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_n[i])
        busy_n[(push && tail == AW'(i)) ? lsu_rd : rd_q[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[tail] <= lsu_data;
      rd_q[tail]   <= lsu_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      fifo_count <= '0;
      valid_q    <= '0;
      busy_mask  <= '0;
      we         <= 1'b0;
      rw         <= '0;
      busw       <= '0;
      order_err  <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
      valid_q   <= valid_n;
      busy_mask <= busy_n;
      if (alu_sel) begin
        we   <= 1'b1;
        rw   <= alu_rd;
        busw <= alu_data;
        if (busy_mask[alu_rd]) order_err <= 1'b1;
      end else if (pop) begin
        we   <= 1'b1;
        rw   <= rd_q[head];
        busw <= data_q[head];
      end else begin
        we <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_d_wb_arbiter.sv
// tb/tb_d_wb_arbiter.sv - scoreboard bench for d_wb_arbiter
module tb_d_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_we, lsu_valid, lsu_ready, we, order_err;
  logic [4:0]  alu_rd, lsu_rd, rw;
  logic [31:0] alu_data, lsu_data, busw, busy_mask;
  logic [2:0]  fifo_count;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];
  int compared = 0;
  int mismatched = 0;

  d_wb_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_we(alu_we), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .we(we), .rw(rw), .busw(busw), .fifo_count(fifo_count),
    .busy_mask(busy_mask), .order_err(order_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    wr_t w;
    w.rd = rd;
    w.data = data;
    exp_q.push_back(w);
  endtask

  // Monitor: every register-file write must match the oldest expected write
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_rw", {27'd0, rw}, 32'hFFFF_FFFF);
        end else begin
          w = exp_q.pop_front();
          check("write_rw", {27'd0, rw}, {27'd0, w.rd});
          check("write_busw", busw, w.data);
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    alu_we = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_we", {31'd0, we}, 32'd0);
    check("reset_count", {29'd0, fifo_count}, 32'd0);
    check("reset_ready", {31'd0, lsu_ready}, 32'd1);
    check("reset_busy", busy_mask, 32'd0);
    check("reset_order_err", {31'd0, order_err}, 32'd0);

    // ALU only, then rd=0 ALU write and rd=0 push (both produce nothing)
    alu_we = 1'b1; alu_rd = 5'd10; alu_data = 32'h1234_5678;
    expect_wr(5'd10, 32'h1234_5678);
    tick();
    alu_rd = 5'd0; alu_data = 32'hDEAD_BEEF;
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hBAD0;
    tick();
    alu_we = 1'b0; lsu_valid = 1'b0;
    repeat (2) tick();
    check("rd0_push_count", {29'd0, fifo_count}, 32'd0);
    check("rd0_we", {31'd0, we}, 32'd0);

    // Fill to DEPTH while the ALU owns the port, then backpressure
    alu_we = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    for (int k = 1; k <= 4; k++) begin
      lsu_valid = 1'b1; lsu_rd = 5'(k); lsu_data = 32'hA0 + k;
      expect_wr(5'd9, 32'h99);
      tick();
    end
    check("full_count", {29'd0, fifo_count}, 32'd4);
    check("full_ready", {31'd0, lsu_ready}, 32'd0);
    check("full_busy", busy_mask, 32'h0000_001E);
    lsu_rd = 5'd5; lsu_data = 32'hA5;
    repeat (2) begin
      expect_wr(5'd9, 32'h99);
      tick();
    end
    check("held_count", {29'd0, fifo_count}, 32'd4);
    alu_we = 1'b0;
    for (int k = 1; k <= 5; k++) expect_wr(5'(k), 32'hA0 + k);
    n = 0;
    while (!lsu_ready && n < 8) begin
      tick();
      n++;
    end
    check("ready_after_pop_cycles", n, 1);
    tick();
    lsu_valid = 1'b0;
    repeat (6) tick();
    check("drain_count", {29'd0, fifo_count}, 32'd0);

    // Simultaneous push/pop at count 2, across pointer wrap
    alu_we = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    for (int k = 11; k <= 12; k++) begin
      lsu_valid = 1'b1; lsu_rd = 5'(k); lsu_data = 32'hB0 + k;
      expect_wr(5'd9, 32'h99);
      tick();
    end
    check("pp_count_start", {29'd0, fifo_count}, 32'd2);
    alu_we = 1'b0;
    for (int k = 11; k <= 20; k++) expect_wr(5'(k), 32'hB0 + k);
    for (int k = 13; k <= 20; k++) begin
      lsu_rd = 5'(k); lsu_data = 32'hB0 + k;
      tick();
      check("pp_count", {29'd0, fifo_count}, 32'd2);
    end
    lsu_valid = 1'b0;
    repeat (4) tick();
    check("pp_drain_count", {29'd0, fifo_count}, 32'd0);

    // Duplicate rd in the FIFO, busy tracking and ordering violation
    alu_we = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h71;
    expect_wr(5'd3, 32'h33);
    tick();
    lsu_data = 32'h72;
    expect_wr(5'd3, 32'h33);
    tick();
    check("dup_busy", busy_mask, 32'h0000_0080);
    alu_we = 1'b0; lsu_valid = 1'b0;
    expect_wr(5'd7, 32'h71);
    expect_wr(5'd7, 32'h72);
    tick();
    check("dup_busy_after_pop1", busy_mask, 32'h0000_0080);
    tick();
    check("dup_busy_after_pop2", busy_mask, 32'h0000_0000);
    check("no_order_err_yet", {31'd0, order_err}, 32'd0);
    alu_we = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h73;
    expect_wr(5'd3, 32'h33);
    tick();
    lsu_valid = 1'b0;
    alu_rd = 5'd7; alu_data = 32'h7A;
    expect_wr(5'd7, 32'h7A);
    tick();
    check("order_err_set", {31'd0, order_err}, 32'd1);
    alu_rd = 5'd0; alu_data = 32'hFFFF_0000;
    expect_wr(5'd7, 32'h73);
    tick();
    alu_we = 1'b0;
    repeat (2) tick();
    check("order_err_sticky", {31'd0, order_err}, 32'd1);
    check("rd0_alu_no_block_count", {29'd0, fifo_count}, 32'd0);

    // Async reset mid-cycle with 3 entries queued and a write pending
    alu_we = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    for (int k = 21; k <= 23; k++) begin
      lsu_valid = 1'b1; lsu_rd = 5'(k); lsu_data = 32'hC0 + k;
      if (k != 23) expect_wr(5'd3, 32'h33);
      tick();
    end
    check("pre_reset_count", {29'd0, fifo_count}, 32'd3);
    #2;
    rst_n = 1'b0;
    alu_we = 1'b0; lsu_valid = 1'b0;
    #1;
    check("async_count", {29'd0, fifo_count}, 32'd0);
    check("async_we", {31'd0, we}, 32'd0);
    check("async_busy", busy_mask, 32'd0);
    check("async_order_err", {31'd0, order_err}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("post_reset_count", {29'd0, fifo_count}, 32'd0);
    check("post_reset_we", {31'd0, we}, 32'd0);
    check("exp_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
